// File: rtl/decode_stage_pkg.sv
// Shared constants for the RV32I decode stage: ALU op codes, opcodes, funct fields, immediate
// selects.
package decode_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

    // Base (funct7 = 0) ALU op for OP / OP-IMM.
    function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            F3_ADD_SUB: op = ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: selects and sign-extends the I/S/B/U/J immediate of an RV32I instruction.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_sel_e    sel,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        unique case (sel)
            ImmI: imm = {{20{instr[31]}}, instr[31:20]};
            ImmS: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmU: imm = {instr[31:12], 12'b0};
            ImmJ: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage feeding the execute-stage ALU over a valid/ready handshake.
// Define DECODE_WB_FWD_EN to add the writeback forwarding ports (wb_we/wb_rd/wb_data).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
`ifdef DECODE_WB_FWD_EN
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic [XLEN-1:0] out_alu_a,
    output logic [XLEN-1:0] out_alu_b,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [2:0]      out_funct3,
    output logic            out_is_branch,
    output logic            out_is_jump,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_val, rs2_val, imm;
    imm_sel_e        imm_sel;
    logic            capture;

    logic [3:0]      d_op;
    logic [XLEN-1:0] d_a, d_b, d_imm;
    logic            legal, writes, d_br, d_jp, d_ld, d_st;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign funct7   = in_instr[31:25];

`ifdef DECODE_WB_FWD_EN
    always_comb begin
        rs1_val = rs1_data;
        rs2_val = rs2_data;
        if (wb_we && wb_rd != 5'd0 && wb_rd == rs1_addr) rs1_val = wb_data;
        if (wb_we && wb_rd != 5'd0 && wb_rd == rs2_addr) rs2_val = wb_data;
    end
`else
    assign rs1_val = rs1_data;
    assign rs2_val = rs2_data;
`endif

    // Kept separate from the main decode so imm feeds d_b without a combinational loop.
    always_comb begin
        case (opcode)
            OPC_STORE:          imm_sel = ImmS;
            OPC_BRANCH:         imm_sel = ImmB;
            OPC_LUI, OPC_AUIPC: imm_sel = ImmU;
            OPC_JAL:            imm_sel = ImmJ;
            default:            imm_sel = ImmI;
        endcase
    end

    decode_stage_imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .sel   (imm_sel),
        .imm   (imm)
    );

    always_comb begin
        d_op   = ALU_ADD;
        d_a    = '0;
        d_b    = '0;
        d_imm  = imm;
        legal  = (in_instr[1:0] == 2'b11);
        writes = 1'b0;
        d_br   = 1'b0;
        d_jp   = 1'b0;
        d_ld   = 1'b0;
        d_st   = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_a    = rs1_val;
                d_b    = rs2_val;
                d_imm  = '0;
                writes = 1'b1;
                d_op   = alu_op_from_f3(funct3);
                if (funct7 == F7_ALT && funct3 == F3_ADD_SUB)      d_op  = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) d_op  = ALU_SRA;
                else if (funct7 != F7_BASE)                        legal = 1'b0;
            end
            OPC_OP_IMM: begin
                d_a    = rs1_val;
                d_b    = imm;
                writes = 1'b1;
                d_op   = alu_op_from_f3(funct3);
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
                    d_b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                    if (funct3 == F3_SRL_SRA && funct7 == F7_ALT) d_op  = ALU_SRA;
                    else if (funct7 != F7_BASE)                   legal = 1'b0;
                end
            end
            OPC_LUI: begin
                d_b    = imm;
                writes = 1'b1;
            end
            OPC_AUIPC: begin
                d_a    = in_pc;
                d_b    = imm;
                writes = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                d_a    = in_pc;
                d_b    = XLEN'(4);
                d_jp   = 1'b1;
                writes = 1'b1;
            end
            OPC_BRANCH: begin
                d_a  = rs1_val;
                d_b  = rs2_val;
                d_br = 1'b1;
                case (funct3)
                    3'b000, 3'b001: d_op = ALU_SUB;
                    3'b100, 3'b101: d_op = ALU_SLT;
                    3'b110, 3'b111: d_op = ALU_SLTU;
                    default:        legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                d_a    = rs1_val;
                d_b    = imm;
                d_ld   = 1'b1;
                writes = 1'b1;
            end
            OPC_STORE: begin
                d_a  = rs1_val;
                d_b  = imm;
                d_st = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            d_op  = ALU_ADD;
            d_a   = '0;
            d_b   = '0;
            d_imm = '0;
            d_br  = 1'b0;
            d_jp  = 1'b0;
            d_ld  = 1'b0;
            d_st  = 1'b0;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_alu_op    <= ALU_ADD;
            out_alu_a     <= '0;
            out_alu_b     <= '0;
            out_imm       <= '0;
            out_rs2_data  <= '0;
            out_pc        <= RESET_PC;
            out_rd        <= '0;
            out_rd_we     <= 1'b0;
            out_funct3    <= '0;
            out_is_branch <= 1'b0;
            out_is_jump   <= 1'b0;
            out_is_load   <= 1'b0;
            out_is_store  <= 1'b0;
            out_illegal   <= 1'b0;
        end else begin
            // Flush suppresses capture and clears a held entry; a stalled entry stays put.
            out_valid <= capture || (out_valid && !out_ready && !flush);
            if (capture) begin
                out_alu_op    <= d_op;
                out_alu_a     <= d_a;
                out_alu_b     <= d_b;
                out_imm       <= d_imm;
                out_rs2_data  <= rs2_val;
                out_pc        <= in_pc;
                out_rd        <= rd;
                out_rd_we     <= legal && writes && (rd != 5'd0);
                out_funct3    <= funct3;
                out_is_branch <= d_br;
                out_is_jump   <= d_jp;
                out_is_load   <= d_ld;
                out_is_store  <= d_st;
                out_illegal   <= !legal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, handshake sequences, and random
// traffic against a behavioural decode model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_ready;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        out_valid, out_rd_we, out_is_branch, out_is_jump, out_is_load, out_is_store;
    logic        out_illegal;
    logic [3:0]  out_alu_op;
    logic [31:0] out_alu_a, out_alu_b, out_imm, out_rs2_data, out_pc;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef DECODE_WB_FWD_EN
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
        .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_imm(out_imm),
        .out_rs2_data(out_rs2_data), .out_pc(out_pc), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_funct3(out_funct3), .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
        .out_is_load(out_is_load), .out_is_store(out_is_store), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a, b, imm, rs2d, pc;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  f3;
        logic        br, jp, ld, st, ill;
    } ent_t;

    typedef struct packed {
        logic [31:0] ins, pc, r1, r2;
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic [4:0]  rd;
        logic        we, ill;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ins, pc, r1, r2, input logic [3:0] op,
                                input logic [31:0] a, b, imm, input logic [4:0] rd,
                                input logic we, ill);
        vec_t v;
        v.ins = ins; v.pc = pc; v.r1 = r1; v.r2 = r2; v.op = op;
        v.a = a; v.b = b; v.imm = imm; v.rd = rd; v.we = we; v.ill = ill;
        return v;
    endfunction

    // Reference decode, written from the ISA rules with plain integer arithmetic.
    function automatic ent_t ref_decode(input logic [31:0] ins, pc, r1, r2);
        ent_t e;
        logic [3:0] base_op [8];
        int iimm, simm, bimm, jimm;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic ok, wr;
        base_op = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        iimm = int'($signed(ins[31:20]));
        simm = int'($signed({ins[31:25], ins[11:7]}));
        bimm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        jimm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e = '0;
        e.pc = pc; e.rd = ins[11:7]; e.f3 = f3; e.rs2d = r2; e.op = ALU_ADD;
        ok = (ins[1:0] == 2'b11);
        wr = 1'b0;
        if (opc == 7'h33) begin
            e.a = r1; e.b = r2; wr = 1'b1; e.op = base_op[f3];
            if (f7 == 7'h20 && f3 == 3'd0) e.op = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_SRA;
            else if (f7 != 7'h00) ok = 1'b0;
        end else if (opc == 7'h13) begin
            e.a = r1; e.b = 32'(iimm); e.imm = 32'(iimm); wr = 1'b1; e.op = base_op[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = 32'(ins[24:20]);
                if (f3 == 3'd5 && f7 == 7'h20) e.op = ALU_SRA;
                else if (f7 != 7'h00) ok = 1'b0;
            end
        end else if (opc == 7'h37 || opc == 7'h17) begin
            e.a = (opc == 7'h17) ? pc : 32'd0;
            e.b = {ins[31:12], 12'h000}; e.imm = e.b; wr = 1'b1;
        end else if (opc == 7'h6F || opc == 7'h67) begin
            e.a = pc; e.b = 32'd4; e.jp = 1'b1; wr = 1'b1;
            e.imm = (opc == 7'h6F) ? 32'(jimm) : 32'(iimm);
        end else if (opc == 7'h63) begin
            e.a = r1; e.b = r2; e.imm = 32'(bimm); e.br = 1'b1;
            if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
            else e.op = (f3 < 3'd4) ? ALU_SUB : (f3 < 3'd6 ? ALU_SLT : ALU_SLTU);
        end else if (opc == 7'h03) begin
            e.a = r1; e.b = 32'(iimm); e.imm = e.b; e.ld = 1'b1; wr = 1'b1;
        end else if (opc == 7'h23) begin
            e.a = r1; e.b = 32'(simm); e.imm = e.b; e.st = 1'b1;
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            e.op = ALU_ADD; e.a = '0; e.b = '0; e.imm = '0;
            e.br = 1'b0; e.jp = 1'b0; e.ld = 1'b0; e.st = 1'b0;
        end
        e.ill = !ok;
        e.we = ok && wr && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic check_entry(input string t, input ent_t e);
        chk({t, ".op"}, 32'(out_alu_op), 32'(e.op));
        chk({t, ".a"}, out_alu_a, e.a);
        chk({t, ".b"}, out_alu_b, e.b);
        chk({t, ".imm"}, out_imm, e.imm);
        chk({t, ".rs2d"}, out_rs2_data, e.rs2d);
        chk({t, ".pc"}, out_pc, e.pc);
        chk({t, ".rd"}, 32'(out_rd), 32'(e.rd));
        chk({t, ".we"}, 32'(out_rd_we), 32'(e.we));
        chk({t, ".f3"}, 32'(out_funct3), 32'(e.f3));
        chk({t, ".flags"}, 32'({out_is_branch, out_is_jump, out_is_load, out_is_store}),
            32'({e.br, e.jp, e.ld, e.st}));
        chk({t, ".ill"}, 32'(out_illegal), 32'(e.ill));
    endtask

    task automatic drive(input logic [31:0] ins, pc, r1, r2);
        in_instr = ins; in_pc = pc; rs1_data = r1; rs2_data = r2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[$];
    logic [6:0] opcs [9];
    ent_t exp_e, nxt;
    logic exp_v, cap, exp_rdy;
    logic [31:0] ri, r1e, r2e;

    initial begin
        vecs.push_back(mk(32'h002081B3, 32'h100, 32'd5, 32'd7, ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0));
        vecs.push_back(mk(32'h402081B3, 32'h104, 32'd5, 32'd7, ALU_SUB, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0));
        vecs.push_back(mk(32'h40335293, 32'h108, 32'h80000000, 32'd1, ALU_SRA, 32'h80000000, 32'd3, 32'h403, 5'd5, 1'b1, 1'b0));
        vecs.push_back(mk(32'hFFF00093, 32'h10C, 32'd0, 32'd9, ALU_ADD, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
        vecs.push_back(mk(32'h123453B7, 32'h110, 32'd11, 32'd12, ALU_ADD, 32'd0, 32'h12345000, 32'h12345000, 5'd7, 1'b1, 1'b0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'h114, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd31, 1'b0, 1'b1));
        vecs.push_back(mk(32'h00001117, 32'h118, 32'd5, 32'd7, ALU_ADD, 32'h118, 32'h1000, 32'h1000, 5'd2, 1'b1, 1'b0));
        vecs.push_back(mk(32'h008000EF, 32'h11C, 32'd5, 32'd7, ALU_ADD, 32'h11C, 32'd4, 32'd8, 5'd1, 1'b1, 1'b0));
        vecs.push_back(mk(32'h00208863, 32'h120, 32'd5, 32'd7, ALU_SUB, 32'd5, 32'd7, 32'd16, 5'd16, 1'b0, 1'b0));
        vecs.push_back(mk(32'h0020E863, 32'h124, 32'd5, 32'd7, ALU_SLTU, 32'd5, 32'd7, 32'd16, 5'd16, 1'b0, 1'b0));
        vecs.push_back(mk(32'h0020A423, 32'h128, 32'd5, 32'd7, ALU_ADD, 32'd5, 32'd8, 32'd8, 5'd8, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFC0A203, 32'h12C, 32'd5, 32'd7, ALU_ADD, 32'd5, 32'hFFFFFFFC, 32'hFFFFFFFC, 5'd4, 1'b1, 1'b0));
        vecs.push_back(mk(32'h022081B3, 32'h130, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1));
        vecs.push_back(mk(32'h0020A863, 32'h134, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd16, 1'b0, 1'b1));
        vecs.push_back(mk(32'h40131293, 32'h138, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd5, 1'b0, 1'b1));
        vecs.push_back(mk(32'h00208033, 32'h13C, 32'd5, 32'd7, ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h0020B1B3, 32'h140, 32'd5, 32'd7, ALU_SLTU, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0));
        vecs.push_back(mk(32'h002081B0, 32'h144, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1));
        opcs = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                 OPC_STORE};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        #12;
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.pc", out_pc, 32'h0);
        chk("reset.op", 32'(out_alu_op), 32'(ALU_ADD));
        chk("reset.a", out_alu_a, 32'h0);
        chk("reset.ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table, one instruction per cycle with the sink always ready.
        in_valid = 1'b1; out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].ins, vecs[i].pc, vecs[i].r1, vecs[i].r2);
            #1;
            chk($sformatf("tbl%0d.rs1_addr", i), 32'(rs1_addr), 32'(vecs[i].ins[19:15]));
            chk($sformatf("tbl%0d.rs2_addr", i), 32'(rs2_addr), 32'(vecs[i].ins[24:20]));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d.op", i), 32'(out_alu_op), 32'(vecs[i].op));
            chk($sformatf("tbl%0d.a", i), out_alu_a, vecs[i].a);
            chk($sformatf("tbl%0d.b", i), out_alu_b, vecs[i].b);
            chk($sformatf("tbl%0d.imm", i), out_imm, vecs[i].imm);
            chk($sformatf("tbl%0d.rd", i), 32'(out_rd), 32'(vecs[i].rd));
            chk($sformatf("tbl%0d.we", i), 32'(out_rd_we), 32'(vecs[i].we));
            chk($sformatf("tbl%0d.ill", i), 32'(out_illegal), 32'(vecs[i].ill));
            chk($sformatf("tbl%0d.pc", i), out_pc, vecs[i].pc);
        end

`ifdef DECODE_WB_FWD_EN
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hAA;
        drive(32'h002081B3, 32'h180, 32'd5, 32'd7);
        @(posedge clk); #1;
        chk("fwd.rs1.a", out_alu_a, 32'hAA);
        chk("fwd.rs1.b", out_alu_b, 32'd7);
        wb_rd = 5'd2;
        @(posedge clk); #1;
        chk("fwd.rs2.b", out_alu_b, 32'hAA);
        chk("fwd.rs2.rs2d", out_rs2_data, 32'hAA);
        wb_we = 1'b0;
`endif

        // Backpressure: entry held while the sink stalls, next one follows with no bubble.
        drive(32'h002081B3, 32'h200, 32'd5, 32'd7);
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(32'h402081B3, 32'h204, 32'd5, 32'd7);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.op", 32'(out_alu_op), 32'(ALU_ADD));
            chk("bp.pc", out_pc, 32'h200);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp.next.valid", 32'(out_valid), 32'd1);
        chk("bp.next.op", 32'(out_alu_op), 32'(ALU_SUB));
        chk("bp.next.pc", out_pc, 32'h204);

        // Flush with a held entry and a presented instruction: both discarded.
        out_ready = 1'b0; flush = 1'b1;
        drive(32'hFFF00093, 32'h208, 32'd0, 32'd0);
        @(posedge clk); #1;
        chk("flush.valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush.dropped", 32'(out_valid), 32'd0);

        // Drain with no new capture.
        in_valid = 1'b1; out_ready = 1'b1;
        drive(32'h002081B3, 32'h300, 32'd1, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain.valid", 32'(out_valid), 32'd0);

        // Random traffic against the reference model.
        exp_v = 1'b0; exp_e = '0;
        for (int c = 0; c < 400; c++) begin
            ri = $urandom;
            if ($urandom_range(0, 9) < 9) ri[6:0] = opcs[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: ri[31:25] = 7'h00;
                1: ri[31:25] = 7'h20;
                default: ;
            endcase
            drive(ri, $urandom, $urandom, $urandom);
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            r1e = rs1_data; r2e = rs2_data;
`ifdef DECODE_WB_FWD_EN
            wb_we = $urandom_range(0, 1) == 1;
            wb_rd = $urandom_range(0, 3) == 0 ? ri[19:15] : 5'($urandom);
            wb_data = $urandom;
            if (wb_we && wb_rd != 0 && wb_rd == ri[19:15]) r1e = wb_data;
            if (wb_we && wb_rd != 0 && wb_rd == ri[24:20]) r2e = wb_data;
`endif
            #1;
            exp_rdy = !exp_v || out_ready;
            chk("rnd.in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rnd.rs1_addr", 32'(rs1_addr), 32'(ri[19:15]));
            cap = in_valid && exp_rdy && !flush;
            nxt = ref_decode(ri, in_pc, r1e, r2e);
            @(posedge clk); #1;
            if (flush) exp_v = 1'b0;
            else if (cap) begin exp_v = 1'b1; exp_e = nxt; end
            else if (out_ready) exp_v = 1'b0;
            chk("rnd.valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) check_entry("rnd", exp_e);
        end
        flush = 1'b0;
        wb_we = 1'b0;

        // Asynchronous reset mid-stream, checked before the next clock edge.
        in_valid = 1'b1; out_ready = 1'b1;
        drive(32'h00001117, 32'h400, 32'd3, 32'd4);
        @(posedge clk); #1;
        chk("pre_rst.pc", out_pc, 32'h400);
        out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_rst.valid", 32'(out_valid), 32'd0);
        chk("async_rst.pc", out_pc, 32'h0);
        chk("async_rst.b", out_alu_b, 32'h0);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst.valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
